// File: rtl/uart_rx_core.sv
// Purpose : 8N1 UART receive front end: synchronise the pin, find start bits, sample mid-bit, strobe each byte.
// Latency : byte_ready fires CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks (+/-1) after rx_s first goes low; +CLKS_PER_BIT with parity.
// Backpressure: none; the consumer must take data_out on the byte_ready pulse (data_out holds until the next good frame).
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        asynchronous, active-low reset
//   uart_rx      raw serial line (idle high, asynchronous to clk)
//   data_out     last correctly framed byte, LSB received first
//   byte_ready   one-cycle pulse when data_out was just updated
//   frame_error  one-cycle pulse when the stop bit samples low
//   parity_error one-cycle pulse on even-parity mismatch (tied low unless UART_RX_PARITY_EN)
//   busy         high whenever the receiver is not idle
//
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit after the 8 data bits.
// Parameters: CLKS_PER_BIT >= 4, SYNC_STAGES >= 2.

module uart_rx_core #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] data_out,
    output logic       byte_ready,
    output logic       frame_error,
    output logic       parity_error,
    output logic       busy
);

    // Counter only ever needs to reach CLKS_PER_BIT-1.
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CNT_W-1:0]       clk_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift_q;
    logic                   parity_q;

    // Synchroniser resets to the idle-high line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            bit_idx      <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            data_out     <= 8'h00;
            byte_ready   <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            byte_ready   <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                // Re-check the start bit at its midpoint; a high line here was a glitch.
                START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // Counter is now aligned to mid-bit, so a full period lands in the middle of each data bit.
                DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt  <= '0;
                        parity_q <= rx_s;
                        state    <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif

                // Leave for IDLE at mid-stop-bit so an immediately following start edge is caught.
                STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (!rx_s) begin
                            frame_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if ((^shift_q) ^ parity_q) begin
                            parity_error <= 1'b1;
`endif
                        end else begin
                            data_out   <= shift_q;
                            byte_ready <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    clk_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Purpose : self-checking bench for uart_rx_core at CLKS_PER_BIT=16 (parity vectors added when UART_RX_PARITY_EN is defined).
// Latency : expected strobes are queued per frame and matched against strobes captured on the falling edge.
// Backpressure: not applicable; the DUT has none.

module tb_uart_rx_core;

    localparam int CPB = 16;
    // Pin edge driven just after posedge c -> strobe visible after posedge c+155 (2 sync + 1 idle + 8 + 9*16).
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 155 + CPB;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] data_out;
    logic       byte_ready;
    logic       frame_error;
    logic       parity_error;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_rx_core #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .data_out    (data_out),
        .byte_ready  (byte_ready),
        .frame_error (frame_error),
        .parity_error(parity_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // flags = {byte_ready, frame_error, parity_error}
    typedef struct {
        logic [2:0] flags;
        logic [7:0] d;
        int         cyc;
    } obs_t;

    typedef struct {
        logic [2:0] flags;
        logic [7:0] d;
        int         t0;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       par_bad;
        logic [2:0] exp_flags;
        logic [7:0] exp_data;
    } vec_t;

    obs_t obs_q[$];
    exp_t exp_q[$];
    vec_t vecs[$];

    always @(negedge clk) begin
        if (byte_ready || frame_error || parity_error)
            obs_q.push_back('{{byte_ready, frame_error, parity_error}, data_out, cyc});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 with the line idle, ready for a back-to-back frame.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbad,
                              input logic [2:0] eflags, input logic [7:0] ed);
        exp_q.push_back('{eflags, ed, cyc});
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ pbad);
`else
        if (pbad) $display("note: parity request ignored in 8N1 build");
`endif
        drive_bit(stop);
        uart_rx = 1'b1;
    endtask

    task automatic check_out(input string name, output int ocyc);
        obs_t o;
        exp_t e;
        int   n;
        int   lat;
        n    = 0;
        ocyc = 0;
        while (obs_q.size() == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: strobe count %0d, expectations %0d, needed one of each", name, obs_q.size(), exp_q.size());
            obs_q.delete();
            exp_q.delete();
            return;
        end
        o    = obs_q.pop_front();
        e    = exp_q.pop_front();
        ocyc = o.cyc;
        chk({name, " flags"}, 32'(o.flags), 32'(e.flags));
        chk({name, " data_out"}, 32'(o.d), 32'(e.d));
        lat = o.cyc - e.t0;
        checks++;
        if (lat < LAT - 2 || lat > LAT + 2) begin
            errors++;
            $display("FAIL %s latency: got %0d, expected %0d +/-2", name, lat, LAT);
        end
    endtask

    task automatic settle(input string name);
        repeat (40) @(posedge clk);
        #1;
        chk({name, " no extra strobe"}, 32'(obs_q.size()), 32'd0);
        chk({name, " busy idle"}, 32'(busy), 32'd0);
        obs_q.delete();
    endtask

    initial begin
        int c1;
        int c2;
        logic [7:0] partial;

        vecs.push_back('{8'hA5, 1'b1, 1'b0, 3'b100, 8'hA5});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 3'b010, 8'hA5});
        vecs.push_back('{8'h11, 1'b1, 1'b0, 3'b100, 8'h11});
`ifdef UART_RX_PARITY_EN
        vecs.push_back('{8'h03, 1'b1, 1'b0, 3'b100, 8'h03});
        vecs.push_back('{8'h03, 1'b1, 1'b1, 3'b001, 8'h03});
        vecs.push_back('{8'h81, 1'b0, 1'b1, 3'b010, 8'h03});
        vecs.push_back('{8'h81, 1'b1, 1'b0, 3'b100, 8'h81});
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset data_out", 32'(data_out), 32'h00);
        chk("reset strobes", 32'({byte_ready, frame_error, parity_error}), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle after reset busy", 32'(busy), 32'd0);

        // Table-driven frames.
        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_bad, vecs[i].exp_flags, vecs[i].exp_data);
            check_out($sformatf("vec%0d", i), c1);
            settle($sformatf("vec%0d", i));
        end

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b0, 3'b100, 8'h00);
        send_frame(8'hFF, 1'b1, 1'b0, 3'b100, 8'hFF);
        check_out("b2b first", c1);
        check_out("b2b second", c2);
        chk("b2b spacing", 32'(c2 - c1), 32'(10 * CPB));
        settle("b2b");

        // Short low glitch on an idle line.
        uart_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        chk("glitch busy high", 32'(busy), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("glitch busy low", 32'(busy), 32'd0);
        chk("glitch no strobe", 32'(obs_q.size()), 32'd0);
        chk("glitch data_out", 32'(data_out), 32'hFF);

        // Reset in the middle of data bit 4.
        partial = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        uart_rx = partial[4];
        repeat (8) @(posedge clk);
        #1;
        chk("midframe busy", 32'(busy), 32'd1);
        chk("midframe data_out held", 32'(data_out), 32'hFF);
        reset = 1'b0;
        #1;
        chk("midframe reset data_out", 32'(data_out), 32'h00);
        chk("midframe reset busy", 32'(busy), 32'd0);
        chk("midframe reset strobes", 32'({byte_ready, frame_error, parity_error}), 32'd0);
        uart_rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send_frame(8'h7E, 1'b1, 1'b0, 3'b100, 8'h7E);
        check_out("after reset 7E", c1);
        settle("after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Serial receive front end for the GPIO UART path. Synchronises the raw uart_rx pin, detects start bits, samples 8N1 frames at mid-bit, and presents each received byte with a one-cycle strobe. The memory-mapped UART controller consumes the strobe to set its "new data" flag and reads data_out on a DATAOUT access. Pure receiver; the transmit side is a separate block.

Parameters:
CLKS_PER_BIT, 434, system clocks per bit period (50 MHz / 115200); must be >= 4.
SYNC_STAGES, 2, flip-flops in the uart_rx synchroniser; must be >= 2.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  asynchronous, active-low reset.
uart_rx  input  1  raw serial line, idle high, asynchronous to clk.
data_out  output  8  last correctly framed byte, LSB received first; holds value until the next good frame.
byte_ready  output  1  one-cycle pulse when data_out has just been updated.
frame_error  output  1  one-cycle pulse when the stop bit samples low.
parity_error  output  1  one-cycle pulse on parity mismatch; constant 0 unless UART_RX_PARITY_EN is defined.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset==0, async): synchroniser flops=1, state=IDLE, bit counter=0, clock counter=0, shift register=0, data_out=8'h00, byte_ready=0, frame_error=0, parity_error=0, busy=0.
- All decisions use rx_s, the last synchroniser stage. Raw uart_rx never reaches the FSM.
- The clock counter counts up from 0 and resets to 0 on every state or bit transition.
- IDLE: if rx_s==0, go to START with counter=0.
- START: when counter == CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - Sample 0: go to DATA, bit index=0.
  - Sample 1: treat as a glitch and return to IDLE. No strobes.
- DATA: when counter == CLKS_PER_BIT-1, shift rx_s into the shift register MSB-side, right-shift, so bit 0 is received first.
  - After bit index 7, go to STOP (or PARITY if the feature is enabled).
  - Otherwise increment the bit index.
- STOP: when counter == CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: data_out <= shift register and byte_ready=1 for exactly one cycle.
  - Sample 0: frame_error=1 for one cycle and data_out is unchanged.
  - Either way, go to IDLE in the same cycle. Receive resumes mid-stop-bit, so back-to-back frames are not lost.
- Latency: byte_ready asserts (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT clocks after the first cycle rx_s==0 (±1 cycle).
- Line held low after a frame error: IDLE sees rx_s==0 and starts a new frame. No lockout.
- byte_ready, frame_error and parity_error are mutually exclusive in any cycle.
- Reset mid-frame: everything is aborted immediately. No strobe is issued, and data_out returns to 0.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: an even-parity bit follows the 8 data bits. The PARITY state samples it at counter == CLKS_PER_BIT-1 and then goes to STOP.
- In STOP, with the stop bit 1:
  - Parity mismatch (XOR of the 8 data bits and the parity bit != 0): parity_error pulses one cycle, byte_ready is suppressed, and data_out is unchanged.
  - Parity match: byte_ready as above.
- With the stop bit 0, frame_error takes priority.
- Undefined: no PARITY state exists, the frame is 8N1, and parity_error is tied 0.

Test Plan:
Bench uses CLKS_PER_BIT=16, macro undefined unless stated.
1. Reset, then send 8'hA5 as 8N1 -> single byte_ready pulse ~152 clks after start edge; data_out=8'hA5; busy low after.
2. Send 8'h00 then 8'hFF back-to-back with no idle gap -> two byte_ready pulses ~160 clks apart; data_out=8'h00 then 8'hFF.
3. Low glitch of 4 clks on idle line -> FSM returns to IDLE at START mid-sample; no strobes; data_out unchanged.
4. Send 8'h3C with stop bit driven 0 -> frame_error pulse, no byte_ready, data_out keeps previous value; next good frame 8'h11 received correctly.
5. Assert reset at DATA bit 4 of a frame -> all outputs 0 immediately; after release, a fresh 8'h7E frame is received correctly.
6. Macro UART_RX_PARITY_EN defined: send 8'h03 with parity 0 -> byte_ready, data_out=8'h03; send 8'h03 with parity 1 -> parity_error pulse, no byte_ready.
